cmd_scheduler: RTL and testbench

Sequencing controller between the UART command decoder, the ALU, and the UART transmitter. It accepts one decoded command at a time through the `cmd_valid`/`cmd_ack` handshake, starts the ALU and waits for its result with a timeout. It then sends a one-byte response over UART and keeps command and error counters for debug LEDs.

---
 rtl/cmd_scheduler.sv | 116 +++++++++++
 tb/tb_cmd_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_scheduler.sv
// Sequences one decoded command: ALU start, result wait with timeout, one-byte UART response.
// Response leaves 3 cycles after cmd_ack at best; SEND and WAIT_TX stall on tx_busy, and cmd_valid is only sampled in IDLE.
module cmd_scheduler #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   input  logic [1:0] opcode,
   input  logic [2:0] operand1,
   input  logic [2:0] operand2,
   output logic       cmd_ack,
   output logic       alu_start,
   output logic [1:0] alu_opcode,
   output logic [2:0] alu_a,
   output logic [2:0] alu_b,
   input  logic       alu_done,
   input  logic [5:0] alu_result,
   output logic       tx_start,
   output logic [7:0] tx_data,
   input  logic       tx_busy,
   output logic       busy,
   output logic [7:0] cmd_count,
   output logic [7:0] err_count
);

   typedef enum logic [2:0] {IDLE, EXEC, WAIT_ALU, SEND, WAIT_TX} state_t;

   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic [7:0] timer;
   logic [1:0] status;
   logic [5:0] result;
   logic       tx_first;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         timer      <= 8'd0;
         status     <= 2'b00;
         result     <= 6'd0;
         tx_first   <= 1'b0;
         cmd_ack    <= 1'b0;
         alu_start  <= 1'b0;
         alu_opcode <= 2'd0;
         alu_a      <= 3'd0;
         alu_b      <= 3'd0;
         tx_start   <= 1'b0;
         tx_data    <= 8'd0;
         busy       <= 1'b0;
         cmd_count  <= 8'd0;
         err_count  <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  alu_opcode <= opcode;
                  alu_a      <= operand1;
                  alu_b      <= operand2;
                  cmd_ack    <= 1'b1;
                  busy       <= 1'b1;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               cmd_ack   <= 1'b0;
               alu_start <= 1'b1;
               timer     <= 8'd0;
               state     <= WAIT_ALU;
            end
            WAIT_ALU: begin
               alu_start <= 1'b0;
               // A done arriving on the last timer cycle still counts as success.
               if (alu_done) begin
                  result <= alu_result;
                  status <= 2'b00;
                  state  <= SEND;
               end else if (timer == TIMER_LAST) begin
                  result <= 6'd0;
                  status <= 2'b11;
                  if (err_count != 8'hFF)
                     err_count <= err_count + 8'd1;
                  state  <= SEND;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            SEND: begin
               if (!tx_busy) begin
                  tx_data  <= {status, result};
                  tx_start <= 1'b1;
                  tx_first <= 1'b1;
                  state    <= WAIT_TX;
               end
            end
            WAIT_TX: begin
               tx_start <= 1'b0;
               // The UART may not raise tx_busy until a cycle after tx_start.
               if (tx_first) begin
                  tx_first <= 1'b0;
               end else if (!tx_busy) begin
                  cmd_count <= cmd_count + 8'd1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_scheduler.sv
// Randomized bench for cmd_scheduler: the driver pushes predicted responses, the monitor checks them on tx_start / busy fall.
module tb_cmd_scheduler;

   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [1:0] opcode = 2'd0;
   logic [2:0] operand1 = 3'd0;
   logic [2:0] operand2 = 3'd0;
   logic       alu_done = 1'b0;
   logic [5:0] alu_result = 6'd0;
   logic       tx_busy = 1'b0;
   logic       cmd_ack, alu_start, tx_start, busy;
   logic [1:0] alu_opcode;
   logic [2:0] alu_a, alu_b;
   logic [7:0] tx_data, cmd_count, err_count;

   cmd_scheduler #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .opcode(opcode),
      .operand1(operand1), .operand2(operand2), .cmd_ack(cmd_ack),
      .alu_start(alu_start), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_done(alu_done), .alu_result(alu_result), .tx_start(tx_start),
      .tx_data(tx_data), .tx_busy(tx_busy), .busy(busy),
      .cmd_count(cmd_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] byte_v;
      int         tx_lat;    // cycles from alu_start to tx_start
      int         fall_lat;  // cycles from tx_start to busy low
      logic [7:0] cnt;
      logic [7:0] err;
   } exp_t;

   exp_t exp_q[$];
   int   compared = 0;
   int   mismatched = 0;
   int   exp_cmd = 0;
   int   exp_err = 0;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic finish_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   endtask

   function automatic logic [63:0] all_outs();
      return {28'd0, cmd_ack, alu_start, alu_opcode, alu_a, alu_b, tx_start,
              tx_data, busy, cmd_count, err_count};
   endfunction

   // Monitor: samples 1 time unit after each rising edge.
   initial begin
      int   cyc;
      int   t_alu;
      int   t_tx;
      logic prev_busy;
      exp_t e;
      cyc = 0; t_alu = 0; t_tx = 0; prev_busy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (!reset) begin
            prev_busy = 1'b0;
         end else begin
            if (alu_start) t_alu = cyc;
            if (tx_start) begin
               if (exp_q.size() == 0) begin
                  chk("tx_start_without_cmd", {63'd0, tx_start}, 64'd0);
               end else begin
                  e = exp_q[0];
                  chk("tx_data", {56'd0, tx_data}, {56'd0, e.byte_v});
                  chk("tx_latency", 64'(cyc - t_alu), 64'(e.tx_lat));
               end
               t_tx = cyc;
            end
            if (prev_busy && !busy) begin
               if (exp_q.size() == 0) begin
                  chk("busy_fall_without_cmd", {63'd0, busy}, 64'd1);
               end else begin
                  e = exp_q.pop_front();
                  chk("busy_fall_latency", 64'(cyc - t_tx), 64'(e.fall_lat));
                  chk("cmd_count", {56'd0, cmd_count}, {56'd0, e.cnt});
                  chk("err_count", {56'd0, err_count}, {56'd0, e.err});
               end
            end
            prev_busy = busy;
         end
      end
   end

   // Issues one command from a negedge with the DUT idle.
   // d: WAIT_ALU cycle index carrying alu_done (>= TO means timeout);
   // bcy: tx_busy high for the first bcy cycles from alu_start; b2: tx_busy high b2 cycles from tx_start;
   // abort_at >= 0 asserts reset at that WAIT_ALU index instead of completing.
   task automatic run_cmd(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                          input logic [5:0] res, input int d, input int bcy, input int b2,
                          input int gap, input int abort_at);
      exp_t e;
      int   n;
      int   k;
      int   j;
      bit   timed_out;
      repeat (gap) @(negedge clk);
      timed_out = (d >= TO);
      e.byte_v   = timed_out ? 8'hC0 : {2'b00, res};
      e.tx_lat   = imax(imin(d, TO - 1) + 1, bcy) + 1;
      e.fall_lat = imax(1, b2) + 1;
      exp_cmd    = (exp_cmd + 1) % 256;
      if (timed_out && exp_err < 255) exp_err++;
      e.cnt = 8'(exp_cmd);
      e.err = 8'(exp_err);
      exp_q.push_back(e);

      cmd_valid = 1'b1; opcode = op; operand1 = a; operand2 = b;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n > 50) begin
            chk("cmd_ack_timeout", {63'd0, cmd_ack}, 64'd1);
            finish_run();
         end
      end while (!cmd_ack);
      chk("ack_latency", 64'(n), 64'd1);
      cmd_valid = 1'b0;
      opcode = 2'($urandom); operand1 = 3'($urandom); operand2 = 3'($urandom);
      @(negedge clk);
      chk("alu_start", {63'd0, alu_start}, 64'd1);
      chk("cmd_ack_pulse", {63'd0, cmd_ack}, 64'd0);
      chk("alu_latched", {56'd0, alu_opcode, alu_a, alu_b}, {56'd0, op, a, b});

      k = 0;
      while (!tx_start) begin
         if (k == abort_at) begin
            reset = 1'b0; alu_done = 1'b0; tx_busy = 1'b0;
            repeat (2) begin
               @(negedge clk);
               chk("outputs_in_reset", all_outs(), 64'd0);
            end
            reset = 1'b1;
            void'(exp_q.pop_back());
            exp_cmd = 0;
            exp_err = 0;
            return;
         end
         if (k == 1) chk("alu_start_pulse", {63'd0, alu_start}, 64'd0);
         alu_done   = (k == d) || (k > imin(d, TO - 1) && ($urandom_range(0, 1) == 1));
         alu_result = (k == d) ? res : 6'($urandom);
         tx_busy    = (k < bcy);
         @(negedge clk);
         k++;
         if (k > 400) begin
            chk("tx_start_timeout", {63'd0, tx_start}, 64'd1);
            finish_run();
         end
      end

      j = 0;
      while (busy) begin
         if (j == 1) chk("tx_start_pulse", {63'd0, tx_start}, 64'd0);
         tx_busy  = (j < b2);
         alu_done = 1'($urandom);
         @(negedge clk);
         j++;
         if (j > 400) begin
            chk("busy_fall_timeout", {63'd0, busy}, 64'd0);
            finish_run();
         end
      end
      tx_busy  = 1'b0;
      alu_done = 1'b0;
   endtask

   task automatic run_random(input int count);
      int d;
      for (int i = 0; i < count; i++) begin
         d = ($urandom_range(0, 5) == 0) ? 99 : int'($urandom_range(0, TO + 2));
         run_cmd(2'($urandom), 3'($urandom), 3'($urandom), 6'($urandom), d,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 6)),
                 int'($urandom_range(0, 2)), -1);
      end
   endtask

   initial begin
      // Reset held with a pending command: nothing may respond.
      cmd_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("reset_outputs", all_outs(), 64'd0);
      end
      cmd_valid = 1'b0;
      reset = 1'b1;

      run_cmd(2'b00, 3'd3, 3'd5, 6'd8, 1, 0, 0, 0, -1);       // normal, response 0x08
      run_cmd(2'b01, 3'd2, 3'd6, 6'd33, 99, 0, 0, 1, -1);     // timeout, response 0xC0
      run_cmd(2'b10, 3'd7, 3'd1, 6'd21, TO - 1, 0, 0, 0, -1); // done on the last timer cycle
      run_cmd(2'b11, 3'd4, 3'd4, 6'd63, TO, 0, 0, 0, -1);     // done one cycle too late
      run_cmd(2'b01, 3'd1, 3'd2, 6'd17, 1, 12, 20, 0, -1);    // busy transmitter
      run_random(40);

      run_cmd(2'b10, 3'd5, 3'd3, 6'd9, 99, 0, 0, 0, 2);       // reset mid-WAIT_ALU
      @(negedge clk);
      chk("counters_after_abort", {48'd0, cmd_count, err_count}, 64'd0);

      for (int i = 0; i < 256; i++)
         run_cmd(2'($urandom), 3'($urandom), 3'($urandom), 6'($urandom), 0, 0, 0, 0, -1);
      chk("cmd_count_wrapped", {56'd0, cmd_count}, 64'd0);
      for (int i = 0; i < 256; i++)
         run_cmd(2'($urandom), 3'($urandom), 3'($urandom), 6'($urandom), TO, 0, 0, 0, -1);
      chk("err_count_saturated", {56'd0, err_count}, 64'd255);

      run_random(10);
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      finish_run();
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      mismatched++;
      finish_run();
   end

endmodule
